// File: rtl/qracc_pkg.sv
// Shared types and constants for the QRACC SRAM arbitration logic.
package qracc_pkg;
  localparam int numSramRequesters = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } qracc_sram_arb_state_t;
endpackage

// File: rtl/qracc_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module qracc_rr_arbiter2
  import qracc_pkg::*;
(
  input  logic                         valid0,
  input  logic                         valid1,
  input  logic                         last_grant,
  output logic [numSramRequesters-1:0] grant
);

  always_comb begin
    grant = '0;
    if (valid0 && valid1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/qracc_sram_arbiter.sv
// Shares one single-outstanding SRAM port between two requesters; reads return to the
// requester that issued them through a registered one-cycle strobe.
module qracc_sram_arbiter
  import qracc_pkg::*;
#(
  parameter int numRows = 128,
  parameter int numCols = 32
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       m0_rq_valid_i,
  input  logic                       m0_rq_wr_i,
  input  logic [$clog2(numRows)-1:0] m0_addr_i,
  input  logic [numCols-1:0]         m0_wr_data_i,
  output logic                       m0_rq_ready_o,
  output logic                       m0_rd_valid_o,
  output logic [numCols-1:0]         m0_rd_data_o,
  input  logic                       m1_rq_valid_i,
  input  logic                       m1_rq_wr_i,
  input  logic [$clog2(numRows)-1:0] m1_addr_i,
  input  logic [numCols-1:0]         m1_wr_data_i,
  output logic                       m1_rq_ready_o,
  output logic                       m1_rd_valid_o,
  output logic [numCols-1:0]         m1_rd_data_o,
  output logic                       sram_rq_valid_o,
  output logic                       sram_rq_wr_o,
  output logic [$clog2(numRows)-1:0] sram_addr_o,
  output logic [numCols-1:0]         sram_wr_data_o,
  input  logic                       sram_rq_ready_i,
  input  logic                       sram_rd_valid_i,
  input  logic [numCols-1:0]         sram_rd_data_i
);

  localparam int AddrW = $clog2(numRows);

  qracc_sram_arb_state_t state_reg, state_next;

  logic [numSramRequesters-1:0] grant;
  logic [numSramRequesters-1:0] rq_ready;
  logic [numSramRequesters-1:0] owner_reg;
  logic                         last_grant_reg;
  logic                         wr_reg;
  logic [AddrW-1:0]             addr_reg;
  logic [numCols-1:0]           wr_data_reg;
  logic                         latch_en;
  logic                         rsp_take;

  qracc_rr_arbiter2 u_rr (
    .valid0     (m0_rq_valid_i),
    .valid1     (m1_rq_valid_i),
    .last_grant (last_grant_reg),
    .grant      (grant)
  );

  // Grant only ever names a requester whose valid is high, so ready alone marks a handshake.
  assign rq_ready      = (state_reg == IDLE) ? grant : '0;
  assign m0_rq_ready_o = rq_ready[0];
  assign m1_rq_ready_o = rq_ready[1];

  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|rq_ready) begin
          latch_en   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (sram_rq_ready_i) begin
          state_next = wr_reg ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (sram_rd_valid_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= '0;
      wr_reg         <= 1'b0;
      addr_reg       <= '0;
      wr_data_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (latch_en) begin
        last_grant_reg <= grant[1];
        owner_reg      <= grant;
        wr_reg         <= grant[1] ? m1_rq_wr_i   : m0_rq_wr_i;
        addr_reg       <= grant[1] ? m1_addr_i    : m0_addr_i;
        wr_data_reg    <= grant[1] ? m1_wr_data_i : m0_wr_data_i;
      end
    end
  end

  assign sram_rq_valid_o = (state_reg == ISSUE);
  assign sram_rq_wr_o    = wr_reg;
  assign sram_addr_o     = addr_reg;
  assign sram_wr_data_o  = wr_data_reg;

  assign rsp_take = (state_reg == WAIT_RD) && sram_rd_valid_i;

  genvar gi;
  generate
    for (gi = 0; gi < numSramRequesters; gi++) begin : g_rsp
      logic               rd_valid_reg;
      logic [numCols-1:0] rd_data_reg;

      always_ff @(posedge clk) begin
        if (!nrst) begin
          rd_valid_reg <= 1'b0;
          rd_data_reg  <= '0;
        end else begin
          rd_valid_reg <= rsp_take && owner_reg[gi];
          if (rsp_take && owner_reg[gi]) begin
            rd_data_reg <= sram_rd_data_i;
          end
        end
      end
    end
  endgenerate

  assign m0_rd_valid_o = g_rsp[0].rd_valid_reg;
  assign m0_rd_data_o  = g_rsp[0].rd_data_reg;
  assign m1_rd_valid_o = g_rsp[1].rd_valid_reg;
  assign m1_rd_data_o  = g_rsp[1].rd_data_reg;

endmodule

// File: tb/tb_qracc_sram_arbiter.sv
// Directed and randomized bench for qracc_sram_arbiter; the bench acts as the SRAM
// and predicts grants and read responses from a behavioural model.
module tb_qracc_sram_arbiter;
  localparam int NR = 128;
  localparam int NC = 32;
  localparam int AW = 7;

  logic          clk;
  logic          nrst;
  logic          m0_rq_valid_i, m0_rq_wr_i, m1_rq_valid_i, m1_rq_wr_i;
  logic [AW-1:0] m0_addr_i, m1_addr_i;
  logic [NC-1:0] m0_wr_data_i, m1_wr_data_i;
  logic          m0_rq_ready_o, m0_rd_valid_o, m1_rq_ready_o, m1_rd_valid_o;
  logic [NC-1:0] m0_rd_data_o, m1_rd_data_o;
  logic          sram_rq_valid_o, sram_rq_wr_o;
  logic [AW-1:0] sram_addr_o;
  logic [NC-1:0] sram_wr_data_o;
  logic          sram_rq_ready_i, sram_rd_valid_i;
  logic [NC-1:0] sram_rd_data_i;

  int checks = 0;
  int errors = 0;

  // Model state: requester granted last, SRAM contents, last data seen per port.
  int            exp_last;
  logic [NC-1:0] mem [NR];
  logic [NC-1:0] exp_rd [2];

  qracc_sram_arbiter #(.numRows(NR), .numCols(NC)) dut (
    .clk             (clk),
    .nrst            (nrst),
    .m0_rq_valid_i   (m0_rq_valid_i),
    .m0_rq_wr_i      (m0_rq_wr_i),
    .m0_addr_i       (m0_addr_i),
    .m0_wr_data_i    (m0_wr_data_i),
    .m0_rq_ready_o   (m0_rq_ready_o),
    .m0_rd_valid_o   (m0_rd_valid_o),
    .m0_rd_data_o    (m0_rd_data_o),
    .m1_rq_valid_i   (m1_rq_valid_i),
    .m1_rq_wr_i      (m1_rq_wr_i),
    .m1_addr_i       (m1_addr_i),
    .m1_wr_data_i    (m1_wr_data_i),
    .m1_rq_ready_o   (m1_rq_ready_o),
    .m1_rd_valid_o   (m1_rd_valid_o),
    .m1_rd_data_o    (m1_rd_data_o),
    .sram_rq_valid_o (sram_rq_valid_o),
    .sram_rq_wr_o    (sram_rq_wr_o),
    .sram_addr_o     (sram_addr_o),
    .sram_wr_data_o  (sram_wr_data_o),
    .sram_rq_ready_i (sram_rq_ready_i),
    .sram_rd_valid_i (sram_rd_valid_i),
    .sram_rd_data_i  (sram_rd_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sram_valid"}, sram_rq_valid_o, 0);
    chk({tag, "_sram_wr"}, sram_rq_wr_o, 0);
    chk({tag, "_sram_addr"}, sram_addr_o, 0);
    chk({tag, "_sram_data"}, sram_wr_data_o, 0);
    chk({tag, "_rd_valid"}, {m1_rd_valid_o, m0_rd_valid_o}, 0);
    chk({tag, "_m0_rd_data"}, m0_rd_data_o, 0);
    chk({tag, "_m1_rd_data"}, m1_rd_data_o, 0);
  endtask

  task automatic do_reset();
    m0_rq_valid_i = 0; m1_rq_valid_i = 0;
    sram_rq_ready_i = 0; sram_rd_valid_i = 0;
    nrst = 0;
    cyc();
    cyc();
    chk_all_zero("reset");
    chk("reset_ready", {m1_rq_ready_o, m0_rq_ready_o}, 0);
    nrst = 1;
    exp_last = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask

  // One arbitrated transaction starting in an IDLE cycle; the bench plays the SRAM.
  task automatic txn(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [NC-1:0] d0,
                     input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [NC-1:0] d1,
                     input int stall, input int rdly, input bit hold);
    int            win;
    logic          wr;
    logic [AW-1:0] a;
    logic [NC-1:0] d;
    m0_rq_valid_i = v0; m0_rq_wr_i = w0; m0_addr_i = a0; m0_wr_data_i = d0;
    m1_rq_valid_i = v1; m1_rq_wr_i = w1; m1_addr_i = a1; m1_wr_data_i = d1;
    if (v0 && v1) win = 1 - exp_last;
    else if (v0) win = 0;
    else if (v1) win = 1;
    else win = -1;
    #1;
    chk("grant_m0", m0_rq_ready_o, win == 0);
    chk("grant_m1", m1_rq_ready_o, win == 1);
    chk("idle_sram_valid", sram_rq_valid_o, 0);
    if (win < 0) return;
    exp_last = win;
    wr = (win == 1) ? w1 : w0;
    a  = (win == 1) ? a1 : a0;
    d  = (win == 1) ? d1 : d0;
    $display("txn m%0d %s addr=%0d data=%h stall=%0d", win, wr ? "WR" : "RD", a, d, stall);
    cyc();
    if (!hold) begin
      m0_rq_valid_i = 0;
      m1_rq_valid_i = 0;
    end
    for (int i = 0; i <= stall; i++) begin
      sram_rq_ready_i = (i == stall);
      #1;
      chk("issue_valid", sram_rq_valid_o, 1);
      chk("issue_wr", sram_rq_wr_o, wr);
      chk("issue_addr", sram_addr_o, a);
      if (wr) chk("issue_data", sram_wr_data_o, d);
      chk("issue_ready", {m1_rq_ready_o, m0_rq_ready_o}, 0);
      cyc();
    end
    sram_rq_ready_i = 0;
    if (wr) begin
      mem[a] = d;
      #1;
      chk("post_wr_sram_valid", sram_rq_valid_o, 0);
      chk("post_wr_rd_valid", {m1_rd_valid_o, m0_rd_valid_o}, 0);
      return;
    end
    for (int i = 0; i <= rdly; i++) begin
      sram_rd_valid_i = (i == rdly);
      sram_rd_data_i  = (i == rdly) ? mem[a] : NC'($urandom);
      #1;
      chk("wait_sram_valid", sram_rq_valid_o, 0);
      chk("wait_ready", {m1_rq_ready_o, m0_rq_ready_o}, 0);
      chk("wait_rd_valid", {m1_rd_valid_o, m0_rd_valid_o}, 0);
      cyc();
    end
    sram_rd_valid_i = 0;
    sram_rd_data_i  = NC'($urandom);
    exp_rd[win] = mem[a];
    #1;
    chk("rsp_m0_valid", m0_rd_valid_o, win == 0);
    chk("rsp_m1_valid", m1_rd_valid_o, win == 1);
    chk("rsp_m0_data", m0_rd_data_o, exp_rd[0]);
    chk("rsp_m1_data", m1_rd_data_o, exp_rd[1]);
  endtask

  initial begin
    m0_rq_wr_i = 0; m0_addr_i = '0; m0_wr_data_i = '0;
    m1_rq_wr_i = 0; m1_addr_i = '0; m1_wr_data_i = '0;
    sram_rd_data_i = '0;
    for (int i = 0; i < NR; i++) mem[i] = NC'($urandom);
    do_reset();

    // m0 write, SRAM ready immediately.
    txn(1, 1, 7'd5, 32'hDEADBEEF, 0, 0, '0, '0, 0, 0, 0);
    txn(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0);

    // Both requesters valid continuously from reset.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      txn(1, 1'($urandom), AW'($urandom_range(0, NR - 1)), NC'($urandom),
          1, 1'($urandom), AW'($urandom_range(0, NR - 1)), NC'($urandom), 0, 0, 1);
    end
    m0_rq_valid_i = 0; m1_rq_valid_i = 0;
    cyc();
    cyc();

    // m1 read with a stalled SRAM.
    mem[7] = 32'h12345678;
    txn(0, 0, '0, '0, 1, 0, 7'd7, NC'($urandom), 3, 0, 0);
    chk("m1_read_data", m1_rd_data_o, 32'h12345678);
    cyc();

    // Stray read response while idle.
    sram_rd_valid_i = 1;
    sram_rd_data_i  = NC'($urandom);
    #1;
    chk("stray_sram_valid", sram_rq_valid_o, 0);
    cyc();
    sram_rd_valid_i = 0;
    #1;
    chk("stray_rd_valid", {m1_rd_valid_o, m0_rd_valid_o}, 0);
    chk("stray_m0_data", m0_rd_data_o, exp_rd[0]);
    chk("stray_m1_data", m1_rd_data_o, exp_rd[1]);
    $display("txn stray rd_valid in idle");
    cyc();

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      logic rv0, rv1;
      rv0 = 1'($urandom);
      rv1 = 1'($urandom);
      if (!rv0 && !rv1) rv0 = 1;
      txn(rv0, 1'($urandom), AW'($urandom_range(0, NR - 1)), NC'($urandom),
          rv1, 1'($urandom), AW'($urandom_range(0, NR - 1)), NC'($urandom),
          $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      m0_rq_valid_i = 0; m1_rq_valid_i = 0;
      if ($urandom_range(0, 1) == 1) cyc();
    end
    m0_rq_valid_i = 0; m1_rq_valid_i = 0;
    cyc();

    // Reset while waiting for read data, then a late response.
    m1_rq_valid_i = 1; m1_rq_wr_i = 0; m1_addr_i = 7'd9;
    #1;
    chk("rst_rd_grant", m1_rq_ready_o, 1);
    cyc();
    m1_rq_valid_i = 0;
    sram_rq_ready_i = 1;
    cyc();
    sram_rq_ready_i = 0;
    nrst = 0;
    cyc();
    chk_all_zero("rst_wait");
    nrst = 1;
    exp_last = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    sram_rd_valid_i = 1;
    sram_rd_data_i  = NC'($urandom);
    cyc();
    sram_rd_valid_i = 0;
    #1;
    chk_all_zero("rst_late_rsp");
    cyc();
    chk("rst_late_rsp2", {m1_rd_valid_o, m0_rd_valid_o}, 0);
    $display("txn reset during WAIT_RD");
    txn(1, 1, AW'($urandom_range(0, NR - 1)), NC'($urandom),
        1, 1, AW'($urandom_range(0, NR - 1)), NC'($urandom), 0, 0, 0);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
